// File: rtl/ex_pipe_reg_pkg.sv
// Shared definitions for the ID/EX pipeline register: default field widths
// and the bit layout of the control and data words, so decode (packer) and
// execute (unpacker) agree on every subfield position.
package ex_pipe_reg_pkg;

  // Default widths of the two payload words and the monitor counters
  localparam int unsigned CTRL_W_DEF = 24;
  localparam int unsigned DATA_W_DEF = 169;
  localparam int unsigned CNT_W_DEF  = 16;

  // Control word layout (LSB first)
  localparam int unsigned REG_WE_BIT   = 0;
  localparam int unsigned JALX_BIT     = 1;
  localparam int unsigned BRANCH_LSB   = 2;
  localparam int unsigned BRANCH_W     = 3;
  localparam int unsigned ALU_SRC_BIT  = 5;
  localparam int unsigned ALU_CTRL_LSB = 6;
  localparam int unsigned ALU_CTRL_W   = 4;
  localparam int unsigned OP_LSB       = 10;
  localparam int unsigned OP_W         = 7;
  localparam int unsigned MEM_WE_BIT   = 17;
  localparam int unsigned MEM_RE_BIT   = 18;
  localparam int unsigned WB_CTR_LSB   = 19;
  localparam int unsigned WB_CTR_W     = 2;
  localparam int unsigned RSVD_LSB     = 21;
  localparam int unsigned RSVD_W       = 3;

  // Data word layout (LSB first). PCs are carried as 29-bit word addresses.
  localparam int unsigned IMM_LSB = 0;
  localparam int unsigned IMM_W   = 32;
  localparam int unsigned RD_LSB  = 32;
  localparam int unsigned REG_W   = 5;
  localparam int unsigned PCN_LSB = 37;
  localparam int unsigned PC_W    = 29;
  localparam int unsigned PC_LSB  = 66;
  localparam int unsigned RD1_LSB = 95;
  localparam int unsigned XLEN    = 32;
  localparam int unsigned RD2_LSB = 127;
  localparam int unsigned RS1_LSB = 159;
  localparam int unsigned RS2_LSB = 164;

  // Write-back source selector carried in the wb_ctr subfield
  typedef enum logic [1:0] {
    WB_ALU = 2'd0,
    WB_MEM = 2'd1,
    WB_PC4 = 2'd2,
    WB_IMM = 2'd3
  } wb_sel_e;

  // Structured view of the control word, MSB first, matching the offsets above
  typedef struct packed {
    logic [RSVD_W-1:0]     rsvd;
    wb_sel_e               wb_ctr;
    logic                  mem_re;
    logic                  mem_we;
    logic [OP_W-1:0]       op;
    logic [ALU_CTRL_W-1:0] alu_ctrl;
    logic                  alu_src;
    logic [BRANCH_W-1:0]   branch;
    logic                  jalx;
    logic                  reg_we;
  } ex_ctrl_t;

  // Structured view of the data word, MSB first, matching the offsets above
  typedef struct packed {
    logic [REG_W-1:0] rs2;
    logic [REG_W-1:0] rs1;
    logic [XLEN-1:0]  rd2;
    logic [XLEN-1:0]  rd1;
    logic [PC_W-1:0]  pc;
    logic [PC_W-1:0]  pcn;
    logic [REG_W-1:0] rd;
    logic [IMM_W-1:0] imm;
  } ex_data_t;

  // True when a control word would cause an architectural side effect
  function automatic logic ctrl_has_effect(input ex_ctrl_t c);
    return c.reg_we | c.mem_we | (|c.branch) | c.jalx;
  endfunction

endpackage

// File: rtl/ex_pipe_reg_sat_counter.sv
// Saturating up-counter used for the stage's performance monitors. It
// sticks at all-ones instead of wrapping so long runs stay visibly pegged.
module ex_pipe_reg_sat_counter #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             clr_i,
  input  logic             inc_i,
  output logic [CNT_W-1:0] cnt_o
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Next count: step by one unless already at the ceiling
  always_comb begin
    cnt_d = cnt_q;
    if (inc_i && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // Count register with synchronous clear
  always_ff @(posedge clk) begin
    if (clr_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/ex_pipe_reg.sv
// ID/EX pipeline stage register with valid/ready handshake, optional skid
// entry, flush and bubble insertion. The main entry drives the outputs; an
// empty stage presents an all-zero control word so no stale write enable or
// branch ever reaches execute.
module ex_pipe_reg
  import ex_pipe_reg_pkg::*;
#(
  parameter int unsigned CTRL_W    = CTRL_W_DEF,
  parameter int unsigned DATA_W    = DATA_W_DEF,
  parameter bit          SKID      = 1'b1,
  parameter bit          ZERO_DATA = 1'b0,
  parameter int unsigned CNT_W     = CNT_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DATA_W-1:0] out_data,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  flush_cnt
);

  // Main entry (the one visible to execute)
  logic              main_valid_q;
  logic              main_valid_d;
  logic [CTRL_W-1:0] main_ctrl_q;
  logic [CTRL_W-1:0] main_ctrl_d;
  logic [DATA_W-1:0] main_data_q;
  logic [DATA_W-1:0] main_data_d;

  // Occupancy of the second entry; constant zero in single-entry builds
  logic skid_valid;

  logic accept;
  logic fire;

  assign fire   = main_valid_q & out_ready;
  assign accept = in_valid & in_ready;

  genvar gi;

  generate
    if (SKID) begin : g_skid
      logic              skid_valid_q;
      logic              skid_valid_d;
      logic [CTRL_W-1:0] skid_ctrl_q;
      logic [CTRL_W-1:0] skid_ctrl_d;
      logic [DATA_W-1:0] skid_data_q;
      logic [DATA_W-1:0] skid_data_d;

      // Two-entry routing: refill main from skid first so order is kept;
      // new payload lands in skid only while main is blocked.
      always_comb begin
        main_valid_d = main_valid_q;
        main_ctrl_d  = main_ctrl_q;
        main_data_d  = main_data_q;
        skid_valid_d = skid_valid_q;
        skid_ctrl_d  = skid_ctrl_q;
        skid_data_d  = skid_data_q;
        if (flush) begin
          main_valid_d = 1'b0;
          skid_valid_d = 1'b0;
        end else if (!main_valid_q || fire) begin
          if (skid_valid_q) begin
            // in_ready is low here, so nothing new can arrive this cycle
            main_valid_d = 1'b1;
            main_ctrl_d  = skid_ctrl_q;
            main_data_d  = skid_data_q;
            skid_valid_d = 1'b0;
          end else begin
            main_valid_d = accept;
            if (accept) begin
              main_ctrl_d = in_ctrl;
              main_data_d = in_data;
            end
          end
        end else if (accept) begin
          skid_valid_d = 1'b1;
          skid_ctrl_d  = in_ctrl;
          skid_data_d  = in_data;
        end
      end

      // Skid entry storage
      always_ff @(posedge clk) begin
        if (rst) begin
          skid_valid_q <= 1'b0;
          skid_ctrl_q  <= '0;
          skid_data_q  <= '0;
        end else begin
          skid_valid_q <= skid_valid_d;
          skid_ctrl_q  <= skid_ctrl_d;
          skid_data_q  <= skid_data_d;
        end
      end

      assign skid_valid = skid_valid_q;
      // Ready comes straight from a flop, breaking the ready path upstream
      assign in_ready   = ~skid_valid_q & ~rst;
    end else begin : g_single
      // Single entry: load whenever the slot is free or being drained
      always_comb begin
        main_valid_d = main_valid_q;
        main_ctrl_d  = main_ctrl_q;
        main_data_d  = main_data_q;
        if (flush) begin
          main_valid_d = 1'b0;
        end else if (!main_valid_q || fire) begin
          main_valid_d = accept;
          if (accept) begin
            main_ctrl_d = in_ctrl;
            main_data_d = in_data;
          end
        end
      end

      assign skid_valid = 1'b0;
      assign in_ready   = ~rst & (~main_valid_q | out_ready);
    end
  endgenerate

  // Main entry storage
  always_ff @(posedge clk) begin
    if (rst) begin
      main_valid_q <= 1'b0;
      main_ctrl_q  <= '0;
      main_data_q  <= '0;
    end else begin
      main_valid_q <= main_valid_d;
      main_ctrl_q  <= main_ctrl_d;
      main_data_q  <= main_data_d;
    end
  end

  // Output view: bubbles carry a zero control word
  always_comb begin
    out_valid = main_valid_q;
    out_ctrl  = main_valid_q ? main_ctrl_q : '0;
    out_data  = (ZERO_DATA && !main_valid_q) ? '0 : main_data_q;
  end

  // Performance monitors: index 0 counts stall cycles, index 1 counts
  // flushes that actually killed something.
  logic [1:0]       cnt_inc;
  logic [CNT_W-1:0] cnt_val [2];

  assign cnt_inc[0] = main_valid_q & ~out_ready & ~flush;
  assign cnt_inc[1] = flush & (main_valid_q | skid_valid);

  generate
    for (gi = 0; gi < 2; gi++) begin : g_cnt
      ex_pipe_reg_sat_counter #(
        .CNT_W(CNT_W)
      ) u_cnt (
        .clk  (clk),
        .clr_i(rst),
        .inc_i(cnt_inc[gi]),
        .cnt_o(cnt_val[gi])
      );
    end
  endgenerate

  assign stall_cnt = cnt_val[0];
  assign flush_cnt = cnt_val[1];

endmodule

// File: tb/tb_ex_pipe_reg.sv
// Bench for ex_pipe_reg: a two-entry (skid) instance with 4-bit counters and
// a single-entry instance with zeroed bubble data share one stimulus stream.
// A queue-based model predicts every output each cycle; directed literal
// expectations pin the key scenarios.
module tb_ex_pipe_reg;

  localparam int CW   = 24;
  localparam int DW   = 169;
  localparam int SCW  = 4;
  localparam int NCW  = 16;
  localparam int SMAX = (1 << SCW) - 1;
  localparam int NMAX = (1 << NCW) - 1;

  logic          clk = 1'b0;
  logic          rst;
  logic          flush;
  logic          in_valid;
  logic          out_ready;
  logic [CW-1:0] in_ctrl;
  logic [DW-1:0] in_data;

  logic           s_in_ready, s_out_valid;
  logic [CW-1:0]  s_out_ctrl;
  logic [DW-1:0]  s_out_data;
  logic [SCW-1:0] s_stall_cnt, s_flush_cnt;

  logic           n_in_ready, n_out_valid;
  logic [CW-1:0]  n_out_ctrl;
  logic [DW-1:0]  n_out_data;
  logic [NCW-1:0] n_stall_cnt, n_flush_cnt;

  always #5 clk = ~clk;

  ex_pipe_reg #(
    .CTRL_W(CW), .DATA_W(DW), .SKID(1'b1), .ZERO_DATA(1'b0), .CNT_W(SCW)
  ) u_dut_skid (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(s_in_ready),
    .in_ctrl(in_ctrl), .in_data(in_data),
    .out_valid(s_out_valid), .out_ready(out_ready),
    .out_ctrl(s_out_ctrl), .out_data(s_out_data),
    .stall_cnt(s_stall_cnt), .flush_cnt(s_flush_cnt)
  );

  ex_pipe_reg #(
    .CTRL_W(CW), .DATA_W(DW), .SKID(1'b0), .ZERO_DATA(1'b1), .CNT_W(NCW)
  ) u_dut_single (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(n_in_ready),
    .in_ctrl(in_ctrl), .in_data(in_data),
    .out_valid(n_out_valid), .out_ready(out_ready),
    .out_ctrl(n_out_ctrl), .out_data(n_out_data),
    .stall_cnt(n_stall_cnt), .flush_cnt(n_flush_cnt)
  );

  // Model state: FIFO of held entries per instance, plus counters
  typedef struct packed {
    logic [CW-1:0] c;
    logic [DW-1:0] d;
  } ent_t;

  ent_t          qs[$];
  ent_t          qn[$];
  logic [DW-1:0] s_last;
  int            s_stall, s_flush, n_stall, n_flush;
  int            n_cmp = 0;
  int            n_bad = 0;

  function automatic logic [DW-1:0] mk_data(input logic [CW-1:0] c);
    return {1'b1, {7{c}}};
  endfunction

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Compare every DUT output against the model
  task automatic compare_all();
    logic          ir;
    logic [CW-1:0] ec;
    logic [DW-1:0] ed;
    // two-entry instance: ready while fewer than two entries are held
    ir = !rst && (qs.size() < 2);
    ec = '0;
    ed = s_last;
    if (qs.size() > 0) begin
      ec = qs[0].c;
      ed = qs[0].d;
    end
    chk("s_in_ready", s_in_ready, ir);
    chk("s_out_valid", s_out_valid, qs.size() > 0);
    chk("s_out_ctrl", s_out_ctrl, ec);
    chk("s_out_data", s_out_data, ed);
    chk("s_stall_cnt", s_stall_cnt, s_stall);
    chk("s_flush_cnt", s_flush_cnt, s_flush);
    // single-entry instance: ready when empty or draining; zero bubble data
    ir = !rst && ((qn.size() == 0) || out_ready);
    ec = '0;
    ed = '0;
    if (qn.size() > 0) begin
      ec = qn[0].c;
      ed = qn[0].d;
    end
    chk("n_in_ready", n_in_ready, ir);
    chk("n_out_valid", n_out_valid, qn.size() > 0);
    chk("n_out_ctrl", n_out_ctrl, ec);
    chk("n_out_data", n_out_data, ed);
    chk("n_stall_cnt", n_stall_cnt, n_stall);
    chk("n_flush_cnt", n_flush_cnt, n_flush);
    $display("cycle t=%0t rst=%0b fl=%0b iv=%0b ic=%h or=%0b | skid v=%0b c=%h ir=%0b | single v=%0b c=%h ir=%0b",
             $time, rst, flush, in_valid, in_ctrl, out_ready,
             s_out_valid, s_out_ctrl, s_in_ready, n_out_valid, n_out_ctrl, n_in_ready);
  endtask

  // Advance the model by one clock edge
  task automatic model_step();
    logic s_acc, n_acc;
    ent_t e;
    if (rst) begin
      qs.delete();
      qn.delete();
      s_last  = '0;
      s_stall = 0; s_flush = 0; n_stall = 0; n_flush = 0;
      return;
    end
    s_acc = in_valid && (qs.size() < 2);
    n_acc = in_valid && ((qn.size() == 0) || out_ready);
    if (qs.size() > 0 && !out_ready && !flush && s_stall < SMAX) s_stall++;
    if (qn.size() > 0 && !out_ready && !flush && n_stall < NMAX) n_stall++;
    if (flush && qs.size() > 0 && s_flush < SMAX) s_flush++;
    if (flush && qn.size() > 0 && n_flush < NMAX) n_flush++;
    if (flush) begin
      qs.delete();
      qn.delete();
      return;
    end
    e.c = in_ctrl;
    e.d = in_data;
    if (qs.size() > 0 && out_ready) void'(qs.pop_front());
    if (s_acc) qs.push_back(e);
    if (qn.size() > 0 && out_ready) void'(qn.pop_front());
    if (n_acc) qn.push_back(e);
    if (qs.size() > 0) s_last = qs[0].d;
  endtask

  task automatic drive(input logic r, input logic fl, input logic v,
                       input logic [CW-1:0] c, input logic ordy);
    rst       = r;
    flush     = fl;
    in_valid  = v;
    in_ctrl   = c;
    in_data   = mk_data(c);
    out_ready = ordy;
  endtask

  task automatic sample();
    @(negedge clk);
    compare_all();
  endtask

  task automatic adv();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic cyc(input logic r, input logic fl, input logic v,
                     input logic [CW-1:0] c, input logic ordy);
    drive(r, fl, v, c, ordy);
    sample();
    adv();
  endtask

  initial begin
    // Reset
    drive(1'b1, 1'b0, 1'b0, '0, 1'b1);
    adv();
    sample();
    chk("rst_s_in_ready", s_in_ready, 0);
    chk("rst_n_in_ready", n_in_ready, 0);
    chk("rst_s_out_data", s_out_data, 0);
    adv();
    drive(1'b0, 1'b0, 1'b0, '0, 1'b1);
    sample();
    chk("post_rst_s_in_ready", s_in_ready, 1);
    chk("post_rst_n_in_ready", n_in_ready, 1);
    adv();

    // Stream 1..5 with execute always ready
    for (int k = 1; k <= 5; k++) begin
      drive(1'b0, 1'b0, 1'b1, CW'(k), 1'b1);
      sample();
      if (k > 1) begin
        chk("stream_ctrl", s_out_ctrl, k - 1);
        chk("stream_valid", s_out_valid, 1);
      end
      adv();
    end
    drive(1'b0, 1'b0, 1'b0, '0, 1'b1);
    sample();
    chk("stream_last", s_out_ctrl, 24'h5);
    chk("stream_stall", s_stall_cnt, 0);
    adv();

    // Stall with skid: A, B sent while execute stalls 3 cycles
    cyc(1'b0, 1'b0, 1'b1, 24'h11, 1'b0);
    drive(1'b0, 1'b0, 1'b1, 24'h22, 1'b0);
    sample();
    chk("stall_A_b", s_out_ctrl, 24'h11);
    adv();
    for (int k = 0; k < 2; k++) begin
      drive(1'b0, 1'b0, 1'b1, 24'h33, 1'b0);
      sample();
      chk("stall_full_ready", s_in_ready, 0);
      chk("stall_A_held", s_out_ctrl, 24'h11);
      adv();
    end
    drive(1'b0, 1'b0, 1'b1, 24'h33, 1'b1);
    sample();
    chk("stall_cnt_3", s_stall_cnt, 3);
    chk("release_A", s_out_ctrl, 24'h11);
    chk("release_no_C", s_in_ready, 0);
    adv();
    drive(1'b0, 1'b0, 1'b1, 24'h33, 1'b1);
    sample();
    chk("release_B", s_out_ctrl, 24'h22);
    chk("skid_empty_ready", s_in_ready, 1);
    adv();
    drive(1'b0, 1'b0, 1'b0, '0, 1'b1);
    sample();
    chk("release_C", s_out_ctrl, 24'h33);
    adv();

    // Flush with both entries held and a concurrent input
    cyc(1'b0, 1'b0, 1'b1, 24'h11, 1'b0);
    cyc(1'b0, 1'b0, 1'b1, 24'h22, 1'b0);
    cyc(1'b0, 1'b1, 1'b1, 24'h33, 1'b0);
    drive(1'b0, 1'b0, 1'b0, '0, 1'b0);
    sample();
    chk("flush_valid", s_out_valid, 0);
    chk("flush_ctrl", s_out_ctrl, 0);
    chk("flush_cnt_1", s_flush_cnt, 1);
    chk("flush_ready", s_in_ready, 1);
    adv();
    cyc(1'b0, 1'b1, 1'b0, '0, 1'b0);
    drive(1'b0, 1'b0, 1'b0, '0, 1'b1);
    sample();
    chk("flush_empty_cnt", s_flush_cnt, 1);
    chk("bubble_n_data", n_out_data, 0);
    adv();

    // Toggling out_ready stream
    for (int k = 0; k < 8; k++) begin
      cyc(1'b0, 1'b0, 1'b1, CW'(24'h40 + k), (k % 2) == 0);
    end
    for (int k = 0; k < 4; k++) begin
      cyc(1'b0, 1'b0, 1'b0, '0, 1'b1);
    end

    // Saturation of the 4-bit stall counter
    cyc(1'b0, 1'b0, 1'b1, 24'h55, 1'b0);
    for (int k = 0; k < 20; k++) begin
      cyc(1'b0, 1'b0, 1'b0, '0, 1'b0);
    end
    drive(1'b0, 1'b0, 1'b0, '0, 1'b0);
    sample();
    chk("stall_sat", s_stall_cnt, 15);
    adv();

    // Reset mid-stall
    drive(1'b1, 1'b0, 1'b1, 24'h66, 1'b0);
    sample();
    chk("rst_mid_s_ready", s_in_ready, 0);
    chk("rst_mid_n_ready", n_in_ready, 0);
    adv();
    drive(1'b0, 1'b0, 1'b0, '0, 1'b0);
    sample();
    chk("rst_mid_valid", s_out_valid, 0);
    chk("rst_mid_ctrl", s_out_ctrl, 0);
    chk("rst_mid_stall", s_stall_cnt, 0);
    chk("rst_mid_flush", s_flush_cnt, 0);
    chk("rst_mid_ready1", s_in_ready, 1);
    adv();

    // Simultaneous flush and reset: reset wins, flush not counted
    cyc(1'b0, 1'b0, 1'b1, 24'h77, 1'b0);
    cyc(1'b1, 1'b1, 1'b0, '0, 1'b0);
    drive(1'b0, 1'b0, 1'b0, '0, 1'b1);
    sample();
    chk("rst_flush_cnt", s_flush_cnt, 0);
    chk("rst_flush_valid", s_out_valid, 0);
    adv();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/ex_pipe_reg.md
Name: ex_pipe_reg

Overview:
Parametrised ID/EX-style pipeline stage register carrying a control field and a data field between decode and execute.
- Adds valid/ready handshake, an optional skid entry, synchronous flush and bubble insertion.
- Control bits of an empty stage read as zero, so downstream never sees a stale reg_we/mem_we/branch.
- Saturating stall and flush counters for performance monitoring.

Parameters:
CTRL_W, 24, width of control field (reg_we, jalx, branch, alu ctrls, op, mem_we, wb_ctr, ...)
DATA_W, 169, width of data field (imm, rd, pcn, pc, rd1, rd2, rs1, rs2)
SKID, 1, 1 = two-entry skid buffer with registered in_ready; 0 = single entry with combinational in_ready
ZERO_DATA, 0, 1 = out_data forced to zero when out_valid=0; 0 = out_data holds last value
CNT_W, 16, width of performance counters

Ports:
clk  in  1  clock
rst  in  1  synchronous reset, active-high
flush  in  1  kill all held entries (branch mispredict / trap)
in_valid  in  1  upstream has a decoded instruction
in_ready  out  1  stage can accept this cycle
in_ctrl  in  CTRL_W  control field
in_data  in  DATA_W  data field
out_valid  out  1  execute-side entry valid
out_ready  in  1  execute consumes entry (0 = stall)
out_ctrl  out  CTRL_W  control field; zero when out_valid=0
out_data  out  DATA_W  data field
stall_cnt  out  CNT_W  cycles with out_valid=1 and out_ready=0, saturating
flush_cnt  out  CNT_W  flushes that killed at least one valid entry, saturating

Behaviour:
- Reset: all state cleared; out_valid=0, out_ctrl=0, out_data=0, counters=0. in_ready=0 while rst=1 and 1 on the first cycle after.
- Handshake: accept = in_valid & in_ready; fire = out_valid & out_ready. Payload is captured only on accept. Entries leave only on fire or flush.
- Latency: accepted payload appears on out_* the next cycle when main is empty or firing. Zero combinational path from in_* to out_*.
- SKID=1: two entries, main (drives outputs) and skid; in_ready = ~skid_valid (registered).
  - main empty, or main firing with skid empty: accept goes to main.
  - main valid, not firing: accept goes to skid.
  - main firing, skid valid: skid moves to main, skid empties. No accept is possible this cycle since in_ready=0.
  - Order is strictly preserved; no entry is ever dropped or duplicated.
- SKID=0: single entry; in_ready = ~out_valid | out_ready (combinational). Throughput is 1/cycle.
- Flush (priority over everything): next cycle main and skid are invalid, out_ctrl=0. Any accept in the flush cycle is discarded. in_ready=1 the next cycle.
- Bubble: when out_valid=0, out_ctrl is all-zero regardless of stored contents. out_data follows ZERO_DATA.
- Counters:
  - stall_cnt increments each cycle out_valid & ~out_ready & ~flush.
  - flush_cnt increments when flush=1 and (main_valid|skid_valid).
  - Both hold at 2^CNT_W-1. Reset clears them.
- Simultaneous flush and rst: rst wins, same result.

Decomposition:
- Shared package: CTRL_W/DATA_W defaults and bit-offset constants for each control/data subfield (REG_WE_BIT, BRANCH_LSB, ...) so decode and execute pack/unpack identically.
- One natural sub-module: sat_counter (CNT_W, inc, clr), instanced twice.

Test Plan:
1. Stream: in_valid=1, out_ready=1, ctrl=0x000001..0x000005 on consecutive cycles -> out_ctrl shows 0x000001..0x000005 one cycle later each, out_valid continuous, stall_cnt=0.
2. Stall with skid (SKID=1):
   - Stimulus: send A=0x11, B=0x22 while out_ready=0 for 3 cycles, then release.
   - Required: in_ready=0 after B; out shows A for 3 stall cycles, then A then B.
   - Required: stall_cnt=3, no C accepted until skid empties.
3. Flush with both entries full: A, B held, flush=1 together with in_valid=1 C=0x33 -> next cycle out_valid=0, out_ctrl=0, C discarded, flush_cnt=1, in_ready=1. A second flush on the empty stage leaves flush_cnt=1.
4. SKID=0, out_ready toggling 1,0,1,0 -> in_ready equals ~out_valid|out_ready each cycle, no loss, order preserved. With ZERO_DATA=1, out_data=0 during bubbles.
5. Counter saturation with CNT_W=4: hold stall for 20 cycles -> stall_cnt reaches 15 and stays at 15.
6. Reset mid-stall: A held, out_ready=0, rst=1 for 1 cycle -> out_valid=0, out_ctrl=0, counters=0, in_ready=0 during rst and 1 the next cycle.
